// File: rtl/accum_reg.sv
// rtl/accum_reg.sv - WIDTH-bit accumulator: hold/add/load/clear, carry-lookahead adder, sticky overflow
// State updates on the falling clock edge; reset is asynchronous and active-low.
module accum_reg #(
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             c_in,
  output logic [WIDTH-1:0] acc,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_ADD   = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  mode_e mode_dec;
  assign mode_dec = mode_e'(mode);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] gen, prop, sum_lo;
  logic [WIDTH:0]   carry;
  logic             sum_hi;
  logic             cl_acc, cl_prod;

  // Each carry is expanded as g[i] | p[i]g[i-1] | ... | p[i..0]c_in, so no carry ripples.
  always_comb begin
    gen      = acc_q & din;
    prop     = acc_q ^ din;
    carry    = '0;
    carry[0] = c_in;
    cl_acc   = 1'b0;
    cl_prod  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      cl_acc  = gen[i];
      cl_prod = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        cl_acc  = cl_acc | (cl_prod & gen[j]);
        cl_prod = cl_prod & prop[j];
      end
      carry[i+1] = cl_acc | (cl_prod & c_in);
    end
    sum_lo = prop ^ carry[WIDTH-1:0];
    sum_hi = carry[WIDTH];
  end

  always_comb begin
    acc_d   = acc_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (mode_dec)
      MODE_ADD: begin
        if (SATURATE && sum_hi) begin
          acc_d = {WIDTH{1'b1}};
        end else begin
          acc_d = sum_lo;
        end
        c_out_d = sum_hi;
        ovf_d   = ovf_q | sum_hi;
      end
      MODE_LOAD: begin
        acc_d   = din;
        c_out_d = 1'b0;
      end
      MODE_CLEAR: begin
        acc_d   = '0;
        c_out_d = 1'b0;
        ovf_d   = 1'b0;
      end
      default: begin
        acc_d   = acc_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
      end
    endcase
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc   = acc_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
  assign zero  = (acc_q == '0);

endmodule

// File: tb/tb_accum_reg.sv
// tb/tb_accum_reg.sv - scoreboard bench for accum_reg (3-bit wrap, 3-bit saturate, 8-bit wrap)
// All three instances share stimulus; each has its own reference model.
module tb_accum_reg;

  logic       clk;
  logic       reset_n;
  logic [1:0] mode;
  logic [7:0] din;
  logic       c_in;

  logic [2:0] acc3, acc3s;
  logic [7:0] acc8;
  logic       c3, c3s, c8, o3, o3s, o8, z3, z3s, z8;

  accum_reg #(.WIDTH(3), .SATURATE(1'b0)) dut_w3 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .din(din[2:0]), .c_in(c_in),
    .acc(acc3), .c_out(c3), .ovf(o3), .zero(z3)
  );
  accum_reg #(.WIDTH(3), .SATURATE(1'b1)) dut_w3s (
    .clk(clk), .reset_n(reset_n), .mode(mode), .din(din[2:0]), .c_in(c_in),
    .acc(acc3s), .c_out(c3s), .ovf(o3s), .zero(z3s)
  );
  accum_reg #(.WIDTH(8), .SATURATE(1'b0)) dut_w8 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .din(din), .c_in(c_in),
    .acc(acc8), .c_out(c8), .ovf(o8), .zero(z8)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0][7:0] acc;
    logic [2:0]      c;
    logic [2:0]      o;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  int         m_w[3]   = '{3, 3, 8};
  bit         m_sat[3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] m_acc[3];
  logic       m_c[3];
  logic       m_o[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int w, input bit sat, inout logic [7:0] a, inout logic c,
                       inout logic o, input logic [1:0] md, input logic [7:0] d, input logic ci);
    int mask;
    int s;
    mask = (1 << w) - 1;
    case (md)
      2'b01: begin
        s = int'(a) + (int'(d) & mask) + int'(ci);
        if (s > mask) begin
          c = 1'b1;
          o = 1'b1;
          a = sat ? 8'(mask) : 8'(s & mask);
        end else begin
          c = 1'b0;
          a = 8'(s);
        end
      end
      2'b10: begin
        a = 8'(int'(d) & mask);
        c = 1'b0;
      end
      2'b11: begin
        a = 8'd0;
        c = 1'b0;
        o = 1'b0;
      end
      default: ;
    endcase
  endtask

  function automatic logic [7:0] obs_acc(input int k);
    case (k)
      0:       return {5'd0, acc3};
      1:       return {5'd0, acc3s};
      default: return acc8;
    endcase
  endfunction

  function automatic logic [2:0] obs_c();
    return {c8, c3s, c3};
  endfunction

  function automatic logic [2:0] obs_o();
    return {o8, o3s, o3};
  endfunction

  function automatic logic [2:0] obs_z();
    return {z8, z3s, z3};
  endfunction

  task automatic compare_out();
    exp_t       e;
    logic [2:0] oc, oo, oz;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e  = sb.pop_front();
    oc = obs_c();
    oo = obs_o();
    oz = obs_z();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("acc[%0d]", k), obs_acc(k), e.acc[k]);
      check($sformatf("c_out[%0d]", k), oc[k], e.c[k]);
      check($sformatf("ovf[%0d]", k), oo[k], e.o[k]);
      check($sformatf("zero[%0d]", k), oz[k], (e.acc[k] == 8'd0));
    end
  endtask

  task automatic step(input logic [1:0] md, input logic [7:0] d, input logic ci);
    exp_t       e;
    logic [7:0] a;
    logic       c, o;
    @(posedge clk);
    mode = md;
    din  = d;
    c_in = ci;
    for (int k = 0; k < 3; k++) begin
      a = m_acc[k];
      c = m_c[k];
      o = m_o[k];
      model(m_w[k], m_sat[k], a, c, o, md, d, ci);
      m_acc[k] = a;
      m_c[k]   = c;
      m_o[k]   = o;
      e.acc[k] = a;
      e.c[k]   = c;
      e.o[k]   = o;
    end
    sb.push_back(e);
    @(negedge clk);
    #1;
    compare_out();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 8'd0;
      m_c[k]   = 1'b0;
      m_o[k]   = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    mode    = 2'b00;
    din     = 8'd0;
    c_in    = 1'b0;
    model_reset();
    #23;
    check("rst_acc3", acc3, 0);
    check("rst_c3", c3, 0);
    check("rst_ovf3", o3, 0);
    check("rst_zero3", z3, 1);
    check("rst_acc8", acc8, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // asynchronous reset between edges
    step(2'b10, 8'd5, 1'b0);
    check("load5_acc3", acc3, 5);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("async_acc3", acc3, 0);
    check("async_c3", c3, 0);
    check("async_ovf3", o3, 0);
    check("async_zero3", z3, 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(2'b10, 8'd4, 1'b1);
    check("postrst_acc3", acc3, 4);

    // wrap and saturate
    step(2'b10, 8'd6, 1'b0);
    step(2'b01, 8'd3, 1'b0);
    check("wrap_acc3", acc3, 1);
    check("wrap_c3", c3, 1);
    check("wrap_ovf3", o3, 1);
    check("sat_acc3s", acc3s, 7);
    check("sat_c3s", c3s, 1);
    check("sat_ovf3s", o3s, 1);
    step(2'b01, 8'd1, 1'b0);
    check("wrap2_acc3", acc3, 2);
    check("wrap2_c3", c3, 0);
    check("wrap2_ovf3", o3, 1);
    step(2'b01, 8'd0, 1'b1);
    check("sat_cin_acc3s", acc3s, 7);
    check("sat_cin_c3s", c3s, 1);
    step(2'b01, 8'd0, 1'b0);
    check("sat_nocarry_acc3s", acc3s, 7);
    check("sat_nocarry_c3s", c3s, 0);

    // carry-in chain, then hold/load/clear
    step(2'b10, 8'd7, 1'b0);
    step(2'b01, 8'd0, 1'b1);
    check("chain_acc3", acc3, 0);
    check("chain_zero3", z3, 1);
    check("chain_c3", c3, 1);
    check("chain_ovf3", o3, 1);
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 8'd5, 1'b1);
      check("hold_acc3", acc3, 0);
      check("hold_c3", c3, 1);
      check("hold_ovf3", o3, 1);
    end
    step(2'b10, 8'd2, 1'b1);
    check("load2_acc3", acc3, 2);
    check("load2_c3", c3, 0);
    check("load2_ovf3", o3, 1);
    step(2'b11, 8'd3, 1'b1);
    check("clear_acc3", acc3, 0);
    check("clear_c3", c3, 0);
    check("clear_ovf3", o3, 0);

    // width scaling
    step(2'b10, 8'd200, 1'b0);
    step(2'b01, 8'd100, 1'b1);
    check("w8_acc", acc8, 45);
    check("w8_c", c8, 1);
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
